reg_file_dump: RTL and testbench

//   Read-side sequencer for a single-read-port register file (combinational read: rdata follows raddr in the same cycle).
//   On a start pulse it walks COUNT entries from START_ADDR, wrapping modulo DEPTH, and streams each word out on a

---
 rtl/reg_file_dump_if.sv | 35 +++
 rtl/reg_file_dump.sv | 120 ++++++++++++
 tb/tb_reg_file_dump.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_dump_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_file_dump_if : control, register-file read port and output stream bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface reg_file_dump_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 1
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   count;
  logic              abort;
  logic [ADDR_W-1:0] raddr_out;
  logic [DATA_W-1:0] rdata_in;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic              busy;
  logic              done;

  // master: the dump sequencer itself
  modport master (
    input  start, start_addr, count, abort, rdata_in, dout_ready,
    output raddr_out, dout, dout_valid, dout_last, busy, done
  );

  // slave: the register file plus the consumer around the sequencer
  modport slave (
    output start, start_addr, count, abort, rdata_in, dout_ready,
    input  raddr_out, dout, dout_valid, dout_last, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_dump.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_file_dump : walks COUNT register-file entries from START_ADDR (wrapping)
//                 and streams them on a valid/ready interface
// Rev 1.0
// ----------------------------------------------------------------------------
module reg_file_dump #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  reg_file_dump_if.master      bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   ONE_CNT   = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [ADDR_W:0]   eff_count;
  logic [ADDR_W-1:0] next_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      raddr_q     <= '0;
      remaining_q <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      remaining_q <= remaining_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    raddr_d     = raddr_q;
    remaining_d = remaining_q;
    dout_d      = dout_q;
    valid_d     = valid_q;
    last_d      = last_q;

    // zero and oversize requests both mean "whole file"
    eff_count = ((bus.count == '0) || (bus.count > DEPTH_CNT)) ? DEPTH_CNT : bus.count;
    next_addr = (raddr_q == LAST_ADDR) ? '0 : raddr_q + ADDR_W'(1);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = RUN;
          raddr_d     = bus.start_addr;
          remaining_d = eff_count;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d     = IDLE;
          valid_d     = 1'b0;
          last_d      = 1'b0;
          remaining_d = '0;
        end else if (!valid_q || bus.dout_ready) begin
          dout_d      = bus.rdata_in;
          valid_d     = 1'b1;
          last_d      = (remaining_q == ONE_CNT);
          remaining_d = remaining_q - ONE_CNT;
          raddr_d     = next_addr;
          if (remaining_q == ONE_CNT) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (valid_q && bus.dout_ready) begin
          state_d = DONE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.raddr_out  = raddr_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.dout_last  = last_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_reg_file_dump.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_reg_file_dump : randomized bench with a transaction-level dump model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_reg_file_dump;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2;
  localparam int ADDR_W = 1;
  localparam int BUDGET = 200;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  reg_file_dump_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  logic [DATA_W-1:0] mem [DEPTH];
  assign bus.rdata_in = mem[bus.raddr_out];

  reg_file_dump #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // 0: always ready, 1: random, 2: toggling, 3: low for first 3 valid cycles
  function automatic logic ready_val(input int mode, input int cyc, input int vcnt);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom % 2);
      2:       return (cyc % 2) == 0;
      default: return vcnt >= 3;
    endcase
  endfunction

  task automatic run_dump(input int sa, input int cnt, input int rmode,
                          input int abort_at, input bit inject_start);
    logic [DATA_W-1:0] exp_q [$];
    int eff, cyc, vcnt, acc;
    bit finished, aborted, prev_stall, rdy;
    logic [DATA_W-1:0] prev_dout;
    logic prev_last;
    logic [ADDR_W-1:0] prev_raddr;

    eff = (cnt == 0 || cnt > DEPTH) ? DEPTH : cnt;
    for (int i = 0; i < eff; i++) exp_q.push_back(mem[(sa + i) % DEPTH]);

    @(negedge clock);
    bus.start      = 1'b1;
    bus.start_addr = sa[ADDR_W-1:0];
    bus.count      = cnt[ADDR_W:0];
    bus.abort      = 1'b0;
    bus.dout_ready = 1'b1;

    @(negedge clock);
    bus.start = 1'b0;
    check_eq("busy_c1", bus.busy, 1);
    check_eq("valid_c1", bus.dout_valid, 0);
    check_eq("raddr_c1", bus.raddr_out, sa);

    cyc = 2; vcnt = 0; acc = 0;
    finished = 0; aborted = 0; prev_stall = 0;
    prev_dout = '0; prev_last = 0; prev_raddr = '0;
    while (!finished && cyc < BUDGET) begin
      @(negedge clock);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (cyc == 2) check_eq("latency_valid", bus.dout_valid, 1);
      if (prev_stall) begin
        check_eq("hold_dout", bus.dout, prev_dout);
        check_eq("hold_last", bus.dout_last, prev_last);
        check_eq("hold_raddr", bus.raddr_out, prev_raddr);
      end
      check_eq("busy_run", bus.busy, 1);
      check_eq("done_early", bus.done, 0);
      check_eq("raddr_walk", bus.raddr_out, (sa + acc + int'(bus.dout_valid)) % DEPTH);
      rdy = ready_val(rmode, cyc, vcnt);
      bus.dout_ready = rdy;
      if (bus.dout_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_word", bus.dout_valid, 0);
          finished = 1;
        end else begin
          check_eq("dout", bus.dout, exp_q[0]);
          check_eq("last", bus.dout_last, exp_q.size() == 1);
          if (abort_at == vcnt) begin
            bus.abort = 1'b1;
            aborted   = 1;
            finished  = 1;
          end
          if (rdy) begin
            void'(exp_q.pop_front());
            acc++;
          end
        end
        vcnt++;
      end
      if (!aborted && exp_q.size() == 0) finished = 1;
      if (inject_start && !finished && ($urandom % 3 == 0)) begin
        bus.start      = 1'b1;
        bus.start_addr = ADDR_W'($urandom);
        bus.count      = (ADDR_W+1)'($urandom);
      end
      prev_stall = bus.dout_valid && !rdy;
      prev_dout  = bus.dout;
      prev_last  = bus.dout_last;
      prev_raddr = bus.raddr_out;
      cyc++;
    end
    check_eq("finished", finished, 1);

    @(negedge clock);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    if (aborted) begin
      check_eq("abort_valid", bus.dout_valid, 0);
      check_eq("abort_last", bus.dout_last, 0);
      check_eq("abort_busy", bus.busy, 0);
      check_eq("abort_done", bus.done, 0);
    end else begin
      check_eq("done_pulse", bus.done, 1);
      check_eq("done_busy", bus.busy, 1);
      check_eq("done_valid", bus.dout_valid, 0);
      check_eq("done_last", bus.dout_last, 0);
      if (inject_start) begin
        bus.start      = 1'b1;
        bus.start_addr = ADDR_W'($urandom);
        bus.count      = (ADDR_W+1)'($urandom);
      end
    end
    @(negedge clock);
    bus.start = 1'b0;
    check_eq("after_done", bus.done, 0);
    check_eq("after_busy", bus.busy, 0);
    check_eq("after_valid", bus.dout_valid, 0);
  endtask

  task automatic reset_mid_dump();
    int waited;
    @(negedge clock);
    bus.start      = 1'b1;
    bus.start_addr = '0;
    bus.count      = '0;
    bus.dout_ready = 1'b0;
    @(negedge clock);
    bus.start = 1'b0;
    waited = 0;
    while (!bus.dout_valid && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    check_eq("rst_pre_valid", bus.dout_valid, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_async_valid", bus.dout_valid, 0);
    check_eq("rst_async_dout", bus.dout, 0);
    check_eq("rst_async_last", bus.dout_last, 0);
    check_eq("rst_async_busy", bus.busy, 0);
    check_eq("rst_async_raddr", bus.raddr_out, 0);
    @(negedge clock);
    reset = 1'b0;
    bus.dout_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check_eq("rst_no_done", bus.done, 0);
      check_eq("rst_idle", bus.busy, 0);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.count      = '0;
    bus.abort      = 1'b0;
    bus.dout_ready = 1'b0;
    mem[0] = 16'hAAAA;
    mem[1] = 16'h5555;
    repeat (2) @(negedge clock);
    check_eq("reset_valid", bus.dout_valid, 0);
    check_eq("reset_last", bus.dout_last, 0);
    check_eq("reset_busy", bus.busy, 0);
    check_eq("reset_done", bus.done, 0);
    check_eq("reset_raddr", bus.raddr_out, 0);
    check_eq("reset_dout", bus.dout, 0);
    reset = 1'b0;

    run_dump(0, 0, 0, -1, 0);
    run_dump(1, 2, 0, -1, 0);
    run_dump(1, 1, 3, -1, 0);
    run_dump(0, 0, 2, -1, 0);
    run_dump(0, 0, 0, 0, 0);
    run_dump(0, 0, 0, -1, 0);
    reset_mid_dump();
    run_dump(0, 0, 1, -1, 1);

    @(negedge clock);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check_eq("idle_abort_busy", bus.busy, 0);
    check_eq("idle_abort_valid", bus.dout_valid, 0);

    for (int t = 0; t < 40; t++) begin
      for (int e = 0; e < DEPTH; e++) mem[e] = DATA_W'($urandom);
      run_dump($urandom_range(0, DEPTH - 1), $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom % 4 == 0) ? int'($urandom % 3) : -1, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
